// File: rtl/mem_pkg.sv
// Shared defaults, FSM state type and block type for the memory block responder.
package mem_pkg;

  localparam int unsigned WORD_LEN    = 32;
  localparam int unsigned ADDRESS_LEN = 12;
  localparam int unsigned BLOCK_WORDS = 4;

  typedef enum logic [1:0] {IDLE, WAIT, FILL, RESP} resp_state_t;

  typedef logic [BLOCK_WORDS*WORD_LEN-1:0] block_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage: synchronous write, asynchronous read, no reset.
module mem_word_array #(
  parameter int unsigned WORD_LEN    = mem_pkg::WORD_LEN,
  parameter int unsigned ADDRESS_LEN = mem_pkg::ADDRESS_LEN
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [ADDRESS_LEN-1:0] addr_i,
  input  logic [WORD_LEN-1:0]    wdata_i,
  output logic [WORD_LEN-1:0]    rdata_o
);

  localparam int unsigned Depth = 2 ** ADDRESS_LEN;

  logic [WORD_LEN-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_block_responder.sv
// Memory-side responder: single-word writes, aligned block reads returned after a fixed
// wait plus one word per cycle of fill.
module mem_block_responder #(
  parameter int unsigned WORD_LEN     = mem_pkg::WORD_LEN,
  parameter int unsigned ADDRESS_LEN  = mem_pkg::ADDRESS_LEN,
  parameter int unsigned BLOCK_WORDS  = mem_pkg::BLOCK_WORDS,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_write_i,
  input  logic [ADDRESS_LEN-1:0]          req_addr_i,
  input  logic [WORD_LEN-1:0]             req_wdata_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [ADDRESS_LEN-1:0]          resp_addr_o,
  output logic [BLOCK_WORDS*WORD_LEN-1:0] resp_block_o,
  output logic                            busy_o
);

  import mem_pkg::*;

  localparam int unsigned CntW   = $clog2(READ_LATENCY + 1);
  localparam int unsigned IdxW   = $clog2(BLOCK_WORDS);
  localparam int unsigned BlockW = BLOCK_WORDS * WORD_LEN;

  resp_state_t            state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [ADDRESS_LEN-1:0] base_q, base_d;
  logic [BlockW-1:0]      block_q, block_d;

  logic                   accept;
  logic                   mem_we;
  logic [ADDRESS_LEN-1:0] mem_addr;
  logic [WORD_LEN-1:0]    mem_rdata;

  assign accept = req_valid_i & req_ready_o;
  assign mem_we = accept & req_write_i;
  // The single port serves requests in IDLE and fill reads in FILL; they never overlap.
  assign mem_addr = (state_q == FILL) ? {base_q[ADDRESS_LEN-1:IdxW], idx_q} : req_addr_i;

  mem_word_array #(
    .WORD_LEN   (WORD_LEN),
    .ADDRESS_LEN(ADDRESS_LEN)
  ) u_word_array (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(req_wdata_i),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    base_d  = base_q;
    block_d = block_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !req_write_i) begin
          base_d  = {req_addr_i[ADDRESS_LEN-1:IdxW], IdxW'(0)};
          cnt_d   = CntW'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          idx_d   = '0;
          state_d = FILL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FILL: begin
        block_d[idx_q*WORD_LEN +: WORD_LEN] = mem_rdata;
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxW'(BLOCK_WORDS - 1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      block_q <= block_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign resp_addr_o  = base_q;
  assign resp_block_o = block_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder with a reference memory model and response scoreboard.
module tb_mem_block_responder;
  import mem_pkg::*;

  localparam int unsigned AW      = ADDRESS_LEN;
  localparam int unsigned WL      = WORD_LEN;
  localparam int unsigned BW      = BLOCK_WORDS * WORD_LEN;
  localparam int unsigned LAT     = 4;
  localparam int          BUDGET  = 50;

  typedef struct {
    logic [AW-1:0] addr;
    block_t        blk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [WL-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [AW-1:0] resp_addr;
  logic [BW-1:0] resp_block;
  logic          busy;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [WL-1:0] model_mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  mem_block_responder #(
    .WORD_LEN    (WL),
    .ADDRESS_LEN (AW),
    .BLOCK_WORDS (BLOCK_WORDS),
    .READ_LATENCY(LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_addr_o (resp_addr),
    .resp_block_o(resp_block),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_block(input logic [AW-1:0] a);
    exp_t e;
    e.addr = a & ~AW'(BLOCK_WORDS - 1);
    e.blk  = '0;
    for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
      logic [AW-1:0] wa;
      wa = e.addr + AW'(i);
      if (model_mem.exists(wa)) e.blk[i*WL +: WL] = model_mem[wa];
    end
    return e;
  endfunction

  // Called at a negedge with a request driven; returns just after the accepting posedge.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, req_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [WL-1:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    wait_accept("write");
    model_mem[a] = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input int hold);
    exp_t e;
    int   edges = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    wait_accept(tag);
    sb.push_back(model_block(a));
    @(negedge clk);
    req_valid = 1'b0;
    while (resp_valid !== 1'b1 && edges < BUDGET) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, edges, LAT + BLOCK_WORDS);
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_addr"}, resp_addr, e.addr);
      check({tag, "_block"}, resp_block, e.blk);
      check({tag, "_ready_low"}, req_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_valid"}, resp_valid, 1'b1);
        check({tag, "_hold_block"}, resp_block, e.blk);
        check({tag, "_hold_addr"}, resp_addr, e.addr);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_done_valid"}, resp_valid, 1'b0);
    check({tag, "_done_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    exp_t e;
    int   c;
    int   resp_cycle;
    int   acc_cycle;
    int   seen;
    logic got_resp;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_addr", resp_addr, '0);
    check("rst_resp_block", resp_block, '0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      write_word(AW'(12'h010 + i), WL'(32'hA0 + i));
      write_word(AW'(12'h020 + i), WL'(32'hB0 + i));
      write_word(AW'(12'hFFC + i), WL'(32'hC0 + i));
    end

    // Block read with backpressure held for five cycles
    do_read("rd_012", 12'h012, 5);

    // Write issued while busy must wait for the read to complete
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 12'h021;
    wait_accept("rd_021");
    sb.push_back(model_block(12'h021));
    @(negedge clk);
    req_write  = 1'b1;
    req_addr   = 12'h020;
    req_wdata  = 32'h5555AAAA;
    resp_ready = 1'b1;
    got_resp   = 1'b0;
    resp_cycle = -1;
    acc_cycle  = -1;
    c = 0;
    while (c < BUDGET) begin
      if (resp_valid === 1'b1 && !got_resp) begin
        got_resp   = 1'b1;
        resp_cycle = c;
        e = sb.pop_front();
        check("busy_wr_resp_addr", resp_addr, e.addr);
        check("busy_wr_resp_block", resp_block, e.blk);
      end
      if (req_ready === 1'b1) begin
        acc_cycle = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    model_mem[12'h020] = 32'h5555AAAA;
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = 1'b0;
    resp_ready = 1'b0;
    check("busy_wr_got_resp", got_resp, 1'b1);
    check("busy_wr_accept_after_resp", acc_cycle, resp_cycle + 1);
    do_read("rd_020_new", 12'h020, 0);

    // Last block in the address space
    do_read("rd_ffc", 12'hFFF, 0);

    // Reset in the middle of a fill discards the read
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 12'h011;
    wait_accept("rd_abort");
    sb.push_back(model_block(12'h011));
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #2;
    check("fill_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_resp_addr", resp_addr, '0);
    check("midrst_resp_block", resp_block, '0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    check("abort_no_resp", seen, 0);
    check("abort_idle", busy, 1'b0);
    do_read("rd_after_rst", 12'h013, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
